rc5_key_sched_ctrl: RTL and testbench
=====================================

Name: rc5_key_sched_ctrl

Overview:
Top-level sequencer for the RC5 key schedule. It packs incoming user-key bytes into the L array and fills the S array with the Pw/Qw magic-constant table. It then resets and starts the key mixer, and owns the S/L RAM port muxes throughout. After mixing completes, it hands the S read port to the encryption datapath and flags the expanded key as valid.

Parameters:
W, 32, word width in bits
C, 4, L-array words; key length in bytes B = 4*C
T, 26, S-array words (2r+2)
PW, 32'hB7E15163, RC5 magic constant P
QW, 32'h9E3779B9, RC5 magic constant Q
Derived (localparam): B = 4*C, C_LENGTH = $clog2(C), T_LENGTH = $clog2(T)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
iLoad  in  1  pulse: begin a new key load (honoured only in IDLE and READY)
iKeyValid  in  1  key byte valid
iKeyByte  in  8  key byte, byte 0 first
oKeyByteReady  out  1  byte accepted when iKeyValid && oKeyByteReady
oMixRst  out  1  active-high reset pulse to the mixer
oMixStart  out  1  start pulse to the mixer
iMixDone  in  1  mixer done (level, sticky until oMixRst)
iMix_S_address  in  T_LENGTH  mixer S port address
iMix_S_data  in  W  mixer S write data
iMix_S_we  in  1  mixer S write enable
iMix_L_address  in  C_LENGTH  mixer L port address
iMix_L_data  in  W  mixer L write data
iMix_L_we  in  1  mixer L write enable
iEnc_S_address  in  T_LENGTH  encryption S read address
oS_address  out  T_LENGTH  S RAM address
oS_data  out  W  S RAM write data
oS_we  out  1  S RAM write enable
oL_address  out  C_LENGTH  L RAM address
oL_data  out  W  L RAM write data
oL_we  out  1  L RAM write enable
oSchedDone  out  1  expanded key valid; encryption owns the S port

Behaviour:
- Reset: rst_n low → state IDLE immediately (async). All registered outputs, counters and accumulators go to 0. Reset mid-operation aborts with no further writes; RAM contents are then undefined.
- States: IDLE, LOAD_KEY, INIT_S, MIX_RST, MIX_START, MIX_WAIT, READY.
- IDLE: all we = 0, oKeyByteReady = 0. iLoad → LOAD_KEY.
- LOAD_KEY: oKeyByteReady = 1. Each accepted byte is shifted into a W-bit packer, little-endian (byte k lands in bits [8(k%4)+7 : 8(k%4)]). On the 4th byte of a word, the next cycle drives oL_we = 1, oL_address = k/4, oL_data = {b3,b2,b1,b0}. Gaps in iKeyValid are allowed. After B bytes, oKeyByteReady drops in the cycle following the last acceptance. State → INIT_S once the last L write has been issued.
- INIT_S: exactly T cycles. Cycle k drives oS_we = 1, oS_address = k, oS_data = PW + k*QW (running accumulator, mod 2^W, no multiplier).
- MIX_RST: 1 cycle, oMixRst = 1, we = 0.
- MIX_START: 1 cycle, oMixStart = 1.
- MIX_WAIT: S/L address, data and we pass combinationally from the iMix_* inputs. iMixDone = 1 → READY.
- READY: oSchedDone = 1. oS_address = iEnc_S_address; oS_we = 0 and oL_we = 0 are forced. iLoad → LOAD_KEY, clearing oSchedDone in the same edge.
- iLoad outside IDLE/READY is ignored. iKeyValid outside LOAD_KEY is ignored.
- iMixDone is ignored outside MIX_WAIT. A stale done from a previous key is cleared by the MIX_RST pulse.
- Controller-owned port values are registered. Port muxes are combinational from the registered state only.
- oMixRst and oMixStart are never high in the same cycle.

Decomposition:
- Shared package rc5_pkg: PW/QW constants for W = 16/32/64, the state encoding as defines, and the C_LENGTH/T_LENGTH derivation.
- One natural sub-module: rc5_key_packer (byte-to-word packer with byte counter and word-write strobe).
- The FSM, S-table generator and port muxes stay in the top block.

Test Plan:
- Reset: drop rst_n mid-clock → all outputs 0 before the next edge; state IDLE; oS_we = oL_we = 0.
- Key load: iLoad, then bytes 0x00..0x0F with one idle cycle inserted after byte 5 → writes L[0] = 32'h03020100, L[1] = 32'h07060504, L[2] = 32'h0B0A0908, L[3] = 32'h0F0E0D0C, in order, one each.
- S init: after the load → 26 consecutive writes with S[0] = 32'hB7E15163, S[1] = 32'h5618CB1C, S[25] = 32'h2B4C3474.
- Mixer handoff: check the 1-cycle oMixRst, then the 1-cycle oMixStart. A mixer model writing S[5] = 32'hDEADBEEF appears on the S port unchanged. Assert iMixDone 200 cycles later → oSchedDone = 1 on the next edge.
- READY: iEnc_S_address = 7 → oS_address = 7, oS_we = 0. Mixer inputs toggling produce no writes.
- Rekey and ignored inputs: iLoad in READY → oSchedDone = 0, new LOAD_KEY. iLoad during INIT_S → ignored, exactly 26 S writes still issued.

Source files
------------

// File: rtl/rc5_key_sched_ctrl_pkg.sv
// Shared definitions for the RC5 key-schedule controller slice.
//   - RC5 magic constants P/Q for word widths 16/32/64
//   - controller state type
//   - address-width derivation helper
package rc5_key_sched_ctrl_pkg;

  localparam logic [15:0] RC5_PW16 = 16'hB7E1;
  localparam logic [15:0] RC5_QW16 = 16'h9E37;
  localparam logic [31:0] RC5_PW32 = 32'hB7E15163;
  localparam logic [31:0] RC5_QW32 = 32'h9E3779B9;
  localparam logic [63:0] RC5_PW64 = 64'hB7E151628AED2A6B;
  localparam logic [63:0] RC5_QW64 = 64'h9E3779B97F4A7C15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_INIT_S,
    ST_MIX_RST,
    ST_MIX_START,
    ST_MIX_WAIT,
    ST_READY
  } state_t;

  // Address width for an n-entry array; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Magic constant P for word width w (zero-extended to 64 bits).
  function automatic logic [63:0] rc5_p(input int unsigned w);
    case (w)
      16:      return {48'd0, RC5_PW16};
      64:      return RC5_PW64;
      default: return {32'd0, RC5_PW32};
    endcase
  endfunction

  // Magic constant Q for word width w (zero-extended to 64 bits).
  function automatic logic [63:0] rc5_q(input int unsigned w);
    case (w)
      16:      return {48'd0, RC5_QW16};
      64:      return RC5_QW64;
      default: return {32'd0, RC5_QW32};
    endcase
  endfunction

endpackage

// File: rtl/rc5_key_sched_ctrl_if.sv
// Bus bundle for rc5_key_sched_ctrl: key-byte handshake, mixer control,
// mixer/encryption RAM requests and the muxed S/L RAM ports.
//   master : the controller (drives o* signals)
//   slave  : the surrounding system (drives i* signals)
interface rc5_key_sched_ctrl_if #(
  parameter int unsigned W = 32,
  parameter int unsigned C = 4,
  parameter int unsigned T = 26
);
  import rc5_key_sched_ctrl_pkg::*;

  localparam int unsigned C_LENGTH = addr_width(C);
  localparam int unsigned T_LENGTH = addr_width(T);

  logic                iLoad;
  logic                iKeyValid;
  logic [7:0]          iKeyByte;
  logic                oKeyByteReady;
  logic                oMixRst;
  logic                oMixStart;
  logic                iMixDone;
  logic [T_LENGTH-1:0] iMix_S_address;
  logic [W-1:0]        iMix_S_data;
  logic                iMix_S_we;
  logic [C_LENGTH-1:0] iMix_L_address;
  logic [W-1:0]        iMix_L_data;
  logic                iMix_L_we;
  logic [T_LENGTH-1:0] iEnc_S_address;
  logic [T_LENGTH-1:0] oS_address;
  logic [W-1:0]        oS_data;
  logic                oS_we;
  logic [C_LENGTH-1:0] oL_address;
  logic [W-1:0]        oL_data;
  logic                oL_we;
  logic                oSchedDone;

  modport master (
    input  iLoad, iKeyValid, iKeyByte, iMixDone,
    input  iMix_S_address, iMix_S_data, iMix_S_we,
    input  iMix_L_address, iMix_L_data, iMix_L_we,
    input  iEnc_S_address,
    output oKeyByteReady, oMixRst, oMixStart,
    output oS_address, oS_data, oS_we,
    output oL_address, oL_data, oL_we,
    output oSchedDone
  );

  modport slave (
    output iLoad, iKeyValid, iKeyByte, iMixDone,
    output iMix_S_address, iMix_S_data, iMix_S_we,
    output iMix_L_address, iMix_L_data, iMix_L_we,
    output iEnc_S_address,
    input  oKeyByteReady, oMixRst, oMixStart,
    input  oS_address, oS_data, oS_we,
    input  oL_address, oL_data, oL_we,
    input  oSchedDone
  );

endinterface

// File: rtl/rc5_key_sched_ctrl_key_packer.sv
// rc5_key_packer: packs user-key bytes little-endian into W-bit L words.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart packing (new key load)
//   accept_i   : byte_i is consumed this cycle
//   byte_i     : key byte
//   full_o     : all B = 4*C bytes have been consumed
//   l_we_o     : registered L write strobe, one cycle after the 4th byte of a word
//   l_addr_o   : L word index of that write
//   l_data_o   : packed word {b3,b2,b1,b0}
module rc5_key_packer
  import rc5_key_sched_ctrl_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned C = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           accept_i,
  input  logic [7:0]                     byte_i,
  output logic                           full_o,
  output logic                           l_we_o,
  output logic [addr_width(C)-1:0]       l_addr_o,
  output logic [W-1:0]                   l_data_o
);

  localparam int unsigned B        = 4 * C;
  localparam int unsigned C_LENGTH = addr_width(C);
  localparam int unsigned CNT_W    = addr_width(B + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]        word_q, word_d;
  logic                l_we_q, l_we_d;
  logic [C_LENGTH-1:0] l_addr_q, l_addr_d;
  logic [W-1:0]        l_data_q, l_data_d;
  logic [1:0]          pos;

  assign pos = cnt_q[1:0];

  always_comb begin
    cnt_d    = cnt_q;
    word_d   = word_q;
    l_we_d   = 1'b0;
    l_addr_d = l_addr_q;
    l_data_d = l_data_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      // First byte of a word starts from a clean accumulator.
      word_d = (pos == 2'd0) ? '0 : word_q;
      word_d[8*pos +: 8] = byte_i;
      cnt_d = cnt_q + 1'b1;
      if (pos == 2'd3) begin
        l_we_d   = 1'b1;
        l_addr_d = C_LENGTH'(cnt_q >> 2);
        l_data_d = word_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      word_q   <= '0;
      l_we_q   <= 1'b0;
      l_addr_q <= '0;
      l_data_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      l_we_q   <= l_we_d;
      l_addr_q <= l_addr_d;
      l_data_q <= l_data_d;
    end
  end

  assign full_o   = (cnt_q == CNT_W'(B));
  assign l_we_o   = l_we_q;
  assign l_addr_o = l_addr_q;
  assign l_data_o = l_data_q;

endmodule

// File: rtl/rc5_key_sched_ctrl.sv
// rc5_key_sched_ctrl: RC5 key-schedule sequencer.
// Loads the user key into L, fills S with P + k*Q, pulses the mixer reset
// and start, then hands the S read port to encryption once mixing is done.
//   clk, rst_n : clock, async active-low reset
//   bus        : rc5_key_sched_ctrl_if.master -- key-byte handshake,
//                mixer control, mixer/encryption requests, muxed S/L ports,
//                oSchedDone (expanded key valid)
module rc5_key_sched_ctrl
  import rc5_key_sched_ctrl_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned C  = 4,
  parameter int unsigned T  = 26,
  parameter logic [W-1:0] PW = W'(rc5_p(W)),
  parameter logic [W-1:0] QW = W'(rc5_q(W))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rc5_key_sched_ctrl_if.master  bus
);

  localparam int unsigned C_LENGTH = addr_width(C);
  localparam int unsigned T_LENGTH = addr_width(T);

  state_t              state_q, state_d;
  logic                s_we_q, s_we_d;
  logic [T_LENGTH-1:0] s_addr_q, s_addr_d;
  logic [W-1:0]        s_data_q, s_data_d;
  logic                mix_rst_q, mix_rst_d;
  logic                mix_start_q, mix_start_d;
  logic                done_q, done_d;

  logic                load_ok;
  logic                key_ready;
  logic                key_accept;
  logic                pk_full;
  logic                pk_l_we;
  logic [C_LENGTH-1:0] pk_l_addr;
  logic [W-1:0]        pk_l_data;

  assign load_ok    = bus.iLoad && ((state_q == ST_IDLE) || (state_q == ST_READY));
  assign key_ready  = (state_q == ST_LOAD_KEY) && !pk_full;
  assign key_accept = key_ready && bus.iKeyValid;

  rc5_key_packer #(
    .W (W),
    .C (C)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (load_ok),
    .accept_i (key_accept),
    .byte_i   (bus.iKeyByte),
    .full_o   (pk_full),
    .l_we_o   (pk_l_we),
    .l_addr_o (pk_l_addr),
    .l_data_o (pk_l_data)
  );

  // Next state and registered controller outputs. S-port values are
  // prepared one cycle ahead so INIT_S cycle k presents S[k] from a flop.
  always_comb begin
    state_d     = state_q;
    s_we_d      = 1'b0;
    s_addr_d    = s_addr_q;
    s_data_d    = s_data_q;
    mix_rst_d   = 1'b0;
    mix_start_d = 1'b0;
    done_d      = done_q;
    case (state_q)
      ST_IDLE: begin
        if (load_ok) state_d = ST_LOAD_KEY;
      end
      ST_LOAD_KEY: begin
        // Leave once the final L word write is on the port.
        if (pk_full && pk_l_we) begin
          state_d  = ST_INIT_S;
          s_we_d   = 1'b1;
          s_addr_d = '0;
          s_data_d = PW;
        end
      end
      ST_INIT_S: begin
        if (s_addr_q == T_LENGTH'(T - 1)) begin
          state_d   = ST_MIX_RST;
          mix_rst_d = 1'b1;
        end else begin
          s_we_d   = 1'b1;
          s_addr_d = s_addr_q + 1'b1;
          s_data_d = s_data_q + QW;
        end
      end
      ST_MIX_RST: begin
        state_d     = ST_MIX_START;
        mix_start_d = 1'b1;
      end
      ST_MIX_START: begin
        state_d = ST_MIX_WAIT;
      end
      ST_MIX_WAIT: begin
        if (bus.iMixDone) begin
          state_d = ST_READY;
          done_d  = 1'b1;
        end
      end
      ST_READY: begin
        if (load_ok) begin
          state_d = ST_LOAD_KEY;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_data_q    <= '0;
      mix_rst_q   <= 1'b0;
      mix_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_data_q    <= s_data_d;
      mix_rst_q   <= mix_rst_d;
      mix_start_q <= mix_start_d;
      done_q      <= done_d;
    end
  end

  // RAM port ownership follows the registered state only.
  always_comb begin
    bus.oS_address = s_addr_q;
    bus.oS_data    = s_data_q;
    bus.oS_we      = s_we_q;
    bus.oL_address = pk_l_addr;
    bus.oL_data    = pk_l_data;
    bus.oL_we      = pk_l_we;
    case (state_q)
      ST_MIX_WAIT: begin
        bus.oS_address = bus.iMix_S_address;
        bus.oS_data    = bus.iMix_S_data;
        bus.oS_we      = bus.iMix_S_we;
        bus.oL_address = bus.iMix_L_address;
        bus.oL_data    = bus.iMix_L_data;
        bus.oL_we      = bus.iMix_L_we;
      end
      ST_READY: begin
        bus.oS_address = bus.iEnc_S_address;
        bus.oS_we      = 1'b0;
        bus.oL_we      = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.oKeyByteReady = key_ready;
  assign bus.oMixRst       = mix_rst_q;
  assign bus.oMixStart     = mix_start_q;
  assign bus.oSchedDone    = done_q;

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
module tb_rc5_key_sched_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned C = 4;
  localparam int unsigned T = 26;
  localparam logic [31:0] P_CONST = 32'hB7E15163;
  localparam logic [31:0] Q_CONST = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc5_key_sched_ctrl_if #(.W(W), .C(C), .T(T)) bus ();

  rc5_key_sched_ctrl #(
    .W  (W),
    .C  (C),
    .T  (T),
    .PW (P_CONST),
    .QW (Q_CONST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] key [16];
  int l_idx = 0, s_idx = 0, l_total = 0, s_total = 0;
  bit mix_phase = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: L word w is the 4 key bytes of that word, byte 0 lowest.
  function automatic logic [31:0] exp_l(input int w);
    return {key[4*w+3], key[4*w+2], key[4*w+1], key[4*w]};
  endfunction

  // Reference model: S[k] = P + k*Q mod 2^32.
  function automatic logic [31:0] exp_s(input int k);
    logic [31:0] kk;
    kk = k;
    return P_CONST + kk * Q_CONST;
  endfunction

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      l_idx = 0;
      s_idx = 0;
      mix_phase = 1'b0;
    end else begin
      chk("mixrst_start_excl", {63'd0, bus.oMixRst & bus.oMixStart}, 64'd0);
      if (bus.oSchedDone) begin
        mix_phase = 1'b0;
        chk("ready_s_addr", bus.oS_address, bus.iEnc_S_address);
        chk("ready_s_we", bus.oS_we, 0);
        chk("ready_l_we", bus.oL_we, 0);
      end else if (mix_phase) begin
        chk("mix_s_addr", bus.oS_address, bus.iMix_S_address);
        chk("mix_s_data", bus.oS_data, bus.iMix_S_data);
        chk("mix_s_we", bus.oS_we, bus.iMix_S_we);
        chk("mix_l_addr", bus.oL_address, bus.iMix_L_address);
        chk("mix_l_data", bus.oL_data, bus.iMix_L_data);
        chk("mix_l_we", bus.oL_we, bus.iMix_L_we);
      end else begin
        if (bus.oS_we) begin
          chk("s_write_addr", bus.oS_address, s_idx);
          chk("s_write_data", bus.oS_data, exp_s(s_idx));
          s_idx = (s_idx + 1) % T;
          s_total++;
        end
        if (bus.oL_we) begin
          chk("l_write_addr", bus.oL_address, l_idx);
          chk("l_write_data", bus.oL_data, exp_l(l_idx));
          l_idx = (l_idx + 1) % C;
          l_total++;
        end
        if (bus.oMixStart) mix_phase = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.iKeyValid = 1'b1;
    bus.iKeyByte  = b;
    n = 0;
    while (!bus.oKeyByteReady && n < 50) begin
      tick();
      n++;
    end
    if (!bus.oKeyByteReady) chk("byte_accept_timeout", 0, 1);
    else tick();
    bus.iKeyValid = 1'b0;
  endtask

  task automatic send_key(input bit gap);
    for (int i = 0; i < 16; i++) begin
      send_byte(key[i]);
      if (gap && i == 5) tick();
    end
    chk("ready_drop_after_last", bus.oKeyByteReady, 0);
  endtask

  task automatic pulse_load();
    bus.iLoad = 1'b1;
    tick();
    bus.iLoad = 1'b0;
  endtask

  task automatic wait_mix_rst(input string name);
    int n;
    n = 0;
    while (!bus.oMixRst && n < 200) begin
      tick();
      n++;
    end
    chk(name, bus.oMixRst, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int lt0, st0, n;
    bus.iLoad = 0; bus.iKeyValid = 0; bus.iKeyByte = '0; bus.iMixDone = 0;
    bus.iMix_S_address = '0; bus.iMix_S_data = '0; bus.iMix_S_we = 0;
    bus.iMix_L_address = '0; bus.iMix_L_data = '0; bus.iMix_L_we = 0;
    bus.iEnc_S_address = '0;
    for (int i = 0; i < 16; i++) key[i] = 8'(i);

    // Reset state
    repeat (3) tick();
    chk("rst_key_ready", bus.oKeyByteReady, 0);
    chk("rst_s_we", bus.oS_we, 0);
    chk("rst_l_we", bus.oL_we, 0);
    chk("rst_sched_done", bus.oSchedDone, 0);
    chk("rst_mix_rst", bus.oMixRst, 0);
    chk("rst_mix_start", bus.oMixStart, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_key_ready", bus.oKeyByteReady, 0);

    // Pin the model to hand-computed values
    chk("model_L0", exp_l(0), 32'h03020100);
    chk("model_L1", exp_l(1), 32'h07060504);
    chk("model_L2", exp_l(2), 32'h0B0A0908);
    chk("model_L3", exp_l(3), 32'h0F0E0D0C);
    chk("model_S0", exp_s(0), 32'hB7E15163);
    chk("model_S1", exp_s(1), 32'h5618CB1C);
    chk("model_S25", exp_s(25), 32'h2B4C3474);

    // Partial load, then asynchronous reset between edges
    pulse_load();
    chk("load_key_ready", bus.oKeyByteReady, 1);
    for (int i = 0; i < 6; i++) send_byte(key[i]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_key_ready", bus.oKeyByteReady, 0);
    chk("async_l_we", bus.oL_we, 0);
    chk("async_l_addr", bus.oL_address, 0);
    chk("async_l_data", bus.oL_data, 0);
    chk("async_s_we", bus.oS_we, 0);
    chk("async_s_addr", bus.oS_address, 0);
    chk("async_s_data", bus.oS_data, 0);
    chk("async_done", bus.oSchedDone, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full load with a gap after byte 5; stale iMixDone must be ignored
    bus.iMixDone = 1'b1;
    lt0 = l_total; st0 = s_total;
    pulse_load();
    send_key(1'b1);
    wait_mix_rst("mix_rst_seen");
    chk("l_write_count", l_total - lt0, 4);
    chk("s_write_count", s_total - st0, 26);
    chk("mix_rst_no_start", bus.oMixStart, 0);
    bus.iMixDone = 1'b0;
    tick();
    chk("mix_rst_one_cycle", bus.oMixRst, 0);
    chk("mix_start_pulse", bus.oMixStart, 1);
    tick();
    chk("mix_start_one_cycle", bus.oMixStart, 0);
    chk("mix_wait_not_done", bus.oSchedDone, 0);

    // Mixer owns the ports
    bus.iMix_S_address = 5'd5; bus.iMix_S_data = 32'hDEADBEEF; bus.iMix_S_we = 1;
    bus.iMix_L_address = 2'd2; bus.iMix_L_data = 32'h12345678; bus.iMix_L_we = 1;
    #1;
    chk("mix_pass_s_addr", bus.oS_address, 5);
    chk("mix_pass_s_data", bus.oS_data, 32'hDEADBEEF);
    chk("mix_pass_s_we", bus.oS_we, 1);
    chk("mix_pass_l_addr", bus.oL_address, 2);
    chk("mix_pass_l_data", bus.oL_data, 32'h12345678);
    chk("mix_pass_l_we", bus.oL_we, 1);
    tick();
    for (int i = 0; i < 199; i++) begin
      bus.iMix_S_address = 5'($urandom_range(25, 0));
      bus.iMix_S_data    = $urandom;
      bus.iMix_S_we      = 1'($urandom_range(1, 0));
      bus.iMix_L_address = 2'($urandom_range(3, 0));
      bus.iMix_L_data    = $urandom;
      bus.iMix_L_we      = 1'($urandom_range(1, 0));
      tick();
    end
    chk("done_before_mixdone", bus.oSchedDone, 0);
    bus.iMixDone = 1'b1;
    tick();
    chk("done_after_mixdone", bus.oSchedDone, 1);

    // READY: encryption owns S, mixer writes are blocked
    bus.iEnc_S_address = 5'd7;
    bus.iMix_S_we = 1; bus.iMix_L_we = 1;
    bus.iKeyValid = 1;
    #1;
    chk("ready_enc_addr7", bus.oS_address, 7);
    chk("ready_no_s_we", bus.oS_we, 0);
    chk("ready_no_l_we", bus.oL_we, 0);
    chk("ready_key_not_ready", bus.oKeyByteReady, 0);
    bus.iKeyValid = 0;
    for (int i = 0; i < 5; i++) begin
      bus.iEnc_S_address = 5'($urandom_range(25, 0));
      bus.iMix_S_address = 5'($urandom_range(25, 0));
      bus.iMix_L_address = 2'($urandom_range(3, 0));
      tick();
    end

    // Rekey from READY; iLoad during INIT_S must be ignored
    for (int i = 0; i < 16; i++) key[i] = 8'(8'hA0 + 8'(i * 7));
    lt0 = l_total; st0 = s_total;
    pulse_load();
    chk("rekey_done_cleared", bus.oSchedDone, 0);
    chk("rekey_key_ready", bus.oKeyByteReady, 1);
    send_key(1'b0);
    n = 0;
    while (!bus.oS_we && n < 20) begin
      tick();
      n++;
    end
    chk("init_s_started", bus.oS_we, 1);
    tick();
    bus.iLoad = 1'b1;
    tick(); tick();
    bus.iLoad = 1'b0;
    wait_mix_rst("rekey_mix_rst_seen");
    chk("rekey_l_write_count", l_total - lt0, 4);
    chk("rekey_s_write_count", s_total - st0, 26);
    bus.iMixDone = 1'b0;
    tick(); tick();
    repeat (10) tick();
    chk("rekey_wait_not_done", bus.oSchedDone, 0);
    bus.iMixDone = 1'b1;
    tick();
    chk("rekey_done", bus.oSchedDone, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
